// File: rtl/shift_sequencer_if.sv
// Host-side bundle for shift_sequencer: command handshake plus status/result.
// Handshake: a command transfers at a posedge where cmd_valid and cmd_ready are
// both high; the host holds cmd_* stable while cmd_valid is high and not yet
// accepted, and the sequencer samples cmd_* only at that transfer edge.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [WIDTH-1:0] result;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill, abort,
    input  cmd_ready, busy, done, aborted, result
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill, abort,
    output cmd_ready, busy, done, aborted, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Command-driven controller for an 8-bit universal shift register. Accepts one
// LOAD/SHL/SHR/ROTL command at a time, drives the register's mode/serial/parallel
// inputs for the needed cycles, then reports the register contents with a
// one-cycle done pulse. The register samples on the negedge of the same clock.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  shift_sequencer_if.slave bus,
  input  logic [WIDTH-1:0] sr_q,
  output logic [1:0]       sr_s,
  output logic [WIDTH-1:0] sr_i,
  output logic             sr_r,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROTL = 2'b11;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       sr_s_q, sr_s_d;
  logic             sr_r_q, sr_r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [WIDTH-1:0] result_q, result_d;

  // State and registered outputs; reset drops any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_LOAD;
      fill_q    <= 1'b0;
      data_q    <= '0;
      sr_s_q    <= MODE_HOLD;
      sr_r_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      fill_q    <= fill_d;
      data_q    <= data_d;
      sr_s_q    <= sr_s_d;
      sr_r_q    <= sr_r_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      result_q  <= result_d;
    end
  end

  // Next state and next registered outputs. Outputs are computed for the state
  // being entered, so they are valid for the whole of that state's cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    fill_d    = fill_q;
    data_d    = data_q;
    sr_s_d    = MODE_HOLD;
    sr_r_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    result_d  = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          cnt_d  = bus.cmd_cnt;
          data_d = bus.cmd_data;
          fill_d = bus.cmd_fill;
          if (bus.cmd_op == OP_LOAD) begin
            state_d = ST_LOAD;
            sr_s_d  = MODE_LOAD;
            busy_d  = 1'b1;
          end else if (bus.cmd_cnt != '0) begin
            state_d = ST_SHIFT;
            sr_s_d  = (bus.cmd_op == OP_SHR) ? MODE_DOWN : MODE_UP;
            // ROTL feeds the MSB back combinationally instead of the fill bit.
            sr_r_d  = (bus.cmd_op == OP_ROTL) ? 1'b0 : bus.cmd_fill;
            busy_d  = 1'b1;
          end else begin
            // Zero-length shift: report the register untouched.
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = sr_q;
          end
        end
      end
      ST_LOAD: begin
        state_d  = ST_DONE;
        done_d   = 1'b1;
        result_d = sr_q;
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (bus.abort || (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1})) begin
          // The shift of the current cycle already happened at the negedge.
          state_d   = ST_DONE;
          cnt_d     = '0;
          done_d    = 1'b1;
          aborted_d = bus.abort;
          result_d  = sr_q;
        end else begin
          sr_s_d = sr_s_q;
          sr_r_d = sr_r_q;
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.result    = result_q;

  assign sr_s = sr_s_q;
  assign sr_i = data_q;
  assign sr_r = ((state_q == ST_SHIFT) && (op_q == OP_ROTL)) ? sr_q[WIDTH-1] : sr_r_q;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: includes a behavioural universal shift register on
// the negedge, directed scenarios followed by random commands, and an
// arithmetic reference model of each command's outcome.
module tb_shift_sequencer;
  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sr_q;
  logic [1:0]   sr_s;
  logic [W-1:0] sr_i;
  logic         sr_r;
  logic [1:0]   dbg_state;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_reg;

  shift_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus();

  shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sr_q       (sr_q),
    .sr_s       (sr_s),
    .sr_i       (sr_i),
    .sr_r       (sr_r),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Controlled register: samples on the negedge, shares the reset.
  always @(negedge clk or posedge reset) begin
    if (reset) sr_q <= '0;
    else begin
      case (sr_s)
        2'b01:   sr_q <= {sr_q[W-2:0], sr_r};
        2'b10:   sr_q <= {sr_r, sr_q[W-1:1]};
        2'b11:   sr_q <= sr_i;
        default: sr_q <= sr_q;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outcome of shifting v by n steps, from the operation's definition.
  function automatic logic [W-1:0] ref_shift(input logic [1:0] op, input int n,
                                             input logic [W-1:0] v, input logic fill);
    int x, m, k, mask, res;
    x    = int'(v);
    mask = (1 << W) - 1;
    m    = (n > W) ? W : n;
    k    = n % W;
    case (op)
      2'b01:   res = ((x << m) | (fill ? ((1 << m) - 1) : 0)) & mask;
      2'b10:   res = (x >> m) | (fill ? (mask & ~(mask >> m)) : 0);
      2'b11:   res = ((x << k) | (x >> (W - k))) & mask;
      default: res = x;
    endcase
    return res[W-1:0];
  endfunction

  task automatic wait_ready_and_accept();
    bit seen;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check_eq("ready timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Issues one command, follows it to done and checks everything observable.
  task automatic run_cmd(input logic [1:0] op, input int cnt, input logic [W-1:0] data,
                         input logic fill, input int abort_at, input bit keep_valid);
    int           n_eff, lat, act;
    bit           ab_exp, got;
    logic [1:0]   mode;
    logic [W-1:0] r, e;
    ab_exp = 0;
    mode   = (op == 2'b00) ? 2'b11 : ((op == 2'b10) ? 2'b10 : 2'b01);
    if (op == 2'b00) begin
      r = data; lat = 2; n_eff = 1;
    end else if (cnt == 0) begin
      r = exp_reg; lat = 1; n_eff = 0;
    end else begin
      if (abort_at >= 1 && abort_at <= cnt) begin
        n_eff = abort_at; ab_exp = 1;
      end else n_eff = cnt;
      r   = ref_shift(op, n_eff, exp_reg, fill);
      lat = n_eff + 1;
    end
    exp_q.push_back(r);

    bus.cmd_op    = op;
    bus.cmd_cnt   = cnt[CW-1:0];
    bus.cmd_data  = data;
    bus.cmd_fill  = fill;
    bus.cmd_valid = 1'b1;
    wait_ready_and_accept();
    if (!keep_valid) begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom_range(0, 3));
      bus.cmd_cnt   = CW'($urandom_range(0, 15));
      bus.cmd_data  = W'($urandom);
      bus.cmd_fill  = 1'($urandom_range(0, 1));
    end

    act = 0;
    got = 0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.done) begin
        got = 1;
        e   = exp_q.pop_front();
        check_eq("latency", c, lat);
        check_eq("result", bus.result, e);
        check_eq("aborted", bus.aborted, ab_exp);
        check_eq("busy in done", bus.busy, 1'b0);
        check_eq("ready in done", bus.cmd_ready, 1'b0);
        check_eq("sr_s in done", sr_s, 2'b00);
        check_eq("sr_r in done", sr_r, 1'b0);
        break;
      end
      check_eq("busy active", bus.busy, 1'b1);
      if (sr_s != 2'b00) begin
        act++;
        check_eq("sr_s mode", sr_s, mode);
        if (op == 2'b00) check_eq("sr_i load", sr_i, data);
        if (op == 2'b01 || op == 2'b10) check_eq("sr_r fill", sr_r, fill);
      end
      bus.abort = (c == abort_at);
      @(posedge clk);
      #1;
    end
    bus.abort = 1'b0;
    if (!got) begin
      check_eq("done timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
    end else begin
      check_eq("active cycles", act, n_eff);
    end
    exp_reg = r;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " sr_s"}, sr_s, 2'b00);
    check_eq({tag, " sr_i"}, sr_i, 8'h00);
    check_eq({tag, " sr_r"}, sr_r, 1'b0);
    check_eq({tag, " busy"}, bus.busy, 1'b0);
    check_eq({tag, " done"}, bus.done, 1'b0);
    check_eq({tag, " aborted"}, bus.aborted, 1'b0);
    check_eq({tag, " result"}, bus.result, 8'h00);
  endtask

  // Stimulus and report
  initial begin
    int op, cnt, ab;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_cnt   = '0;
    bus.cmd_data  = '0;
    bus.cmd_fill  = 1'b0;
    bus.abort     = 1'b0;
    exp_reg       = '0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check_eq("ready after reset", bus.cmd_ready, 1'b1);

    // LOAD
    run_cmd(2'b00, 0, 8'hA5, 1'b0, 0, 0);
    // SHL
    run_cmd(2'b00, 0, 8'h81, 1'b0, 0, 0);
    run_cmd(2'b01, 3, 8'h00, 1'b1, 0, 0);
    // SHR and ROTL with wrap-around
    run_cmd(2'b00, 0, 8'h81, 1'b0, 0, 0);
    run_cmd(2'b10, 2, 8'h00, 1'b0, 0, 0);
    run_cmd(2'b00, 0, 8'h81, 1'b0, 0, 0);
    run_cmd(2'b11, 9, 8'h00, 1'b0, 0, 0);
    // cnt=0 with cmd_valid left high through DONE
    run_cmd(2'b00, 0, 8'h81, 1'b0, 0, 0);
    run_cmd(2'b01, 0, 8'h00, 1'b1, 0, 1);
    // abort in the 3rd shift cycle
    run_cmd(2'b00, 0, 8'hFF, 1'b0, 0, 0);
    run_cmd(2'b10, 8, 8'h00, 1'b0, 3, 0);

    // Reset in the 2nd cycle of SHL cnt=5
    bus.cmd_op    = 2'b01;
    bus.cmd_cnt   = 4'd5;
    bus.cmd_data  = 8'h00;
    bus.cmd_fill  = 1'b1;
    bus.cmd_valid = 1'b1;
    wait_ready_and_accept();
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs("mid reset");
    check_eq("mid reset sr_q", sr_q, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_eq("no done after reset", bus.done, 1'b0);
    end
    reset = 1'b0;
    exp_reg = '0;
    #1 check_eq("ready after mid reset", bus.cmd_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_eq("no done after deassert", bus.done, 1'b0);
    end
    run_cmd(2'b00, 0, 8'h3C, 1'b0, 0, 0);

    // Random commands
    for (int t = 0; t < 40; t++) begin
      op  = $urandom_range(0, 3);
      cnt = $urandom_range(0, 15);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
      run_cmd(op[1:0], cnt, W'($urandom), 1'($urandom_range(0, 1)), ab,
              1'($urandom_range(0, 4) == 0));
    end
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command-driven controller for the 8-bit universal shift register (hold / shift-up / shift-down / parallel-load). It accepts one command at a time over a valid/ready handshake and drives the register's mode select, serial-in and parallel-in for the required number of cycles. When the command finishes, it returns the register contents with a one-cycle done pulse. It sits between a host or FSM and the register, so callers never sequence `s`/`r` directly.

## Interface
- WIDTH, 8, register width; must match the controlled register.
- CNT_W, 4, width of the shift-count field.

- clk  in  1  clock; the controller runs on the posedge, the register samples on the negedge of the same clk.
- reset  in  1  asynchronous, active-high; the register shares this net.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  2  operation code: 00 LOAD, 01 SHL, 10 SHR, 11 ROTL.
- cmd_cnt  in  CNT_W  number of shift cycles (ignored for LOAD).
- cmd_data  in  WIDTH  parallel value for LOAD.
- cmd_fill  in  1  serial fill bit for SHL/SHR.
- abort  in  1  synchronous; terminates SHIFT early.
- sr_q  in  WIDTH  register output.
- sr_s  out  2  register mode: 00 hold, 01 shift-up (bit0←r), 10 shift-down (bit WIDTH-1←r), 11 load.
- sr_i  out  WIDTH  register parallel input.
- sr_r  out  1  register serial input.
- busy  out  1  high in LOAD or SHIFT.
- done  out  1  one-cycle pulse in DONE.
- aborted  out  1  valid with done; 1 if the command was cut short by abort.
- result  out  WIDTH  register value captured on entry to DONE; held until the next DONE.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- **IDLE:** cmd_ready=1, sr_s=00. A handshake (cmd_valid & cmd_ready at posedge) latches op, cnt, data and fill.
  - op=00 → LOAD.
  - op≠00 with cnt≠0 → SHIFT, remaining counter = cnt.
  - op≠00 with cnt=0 → DONE directly. No shift occurs; result = current sr_q.
- **LOAD:** sr_s=11, sr_i=latched data. Lasts 1 cycle, then DONE.
- **SHIFT:** drives sr_s each cycle and decrements the counter; leaves for DONE after the cycle in which the counter was 1.
  - SHL: sr_s=01, sr_r=fill.
  - SHR: sr_s=10, sr_r=fill.
  - ROTL: sr_s=01, sr_r=sr_q[WIDTH-1] (combinational, so each cycle rotates by one).
  - cnt > WIDTH is legal: SHL/SHR fully flush to the fill bit, ROTL wraps modulo WIDTH.
- **DONE:** sr_s=00, done=1, result valid, then IDLE. cmd_ready=0 in DONE, so back-to-back commands are spaced by one IDLE cycle.
- **abort:** sampled only in SHIFT. At the posedge where abort=1, go to DONE with aborted=1; the shift in that cycle has already occurred. abort in IDLE, LOAD or DONE is ignored.
- sr_i = latched data in all states (don't-care outside LOAD). sr_r = 0 outside SHIFT.
- **Reset values** (async, any state): state=IDLE, counter=0, sr_s=00, sr_i=0, sr_r=0, busy=0, done=0, aborted=0, result=0, cmd_ready=1 after deassert.
- **Reset mid-operation:** the command is dropped with no done pulse. The register clears via the shared reset.

## Timing
- Outputs are registered except sr_r in ROTL and cmd_ready (decode of state).
- The register captures at the negedge inside each active cycle. At the following posedge, sr_q already reflects that update; result is sampled at the posedge entering DONE.
- Latency from handshake edge to done high:
  - LOAD: 2 cycles.
  - SHIFT: cnt+1 cycles.
  - cnt=0: 1 cycle.
- Throughput: one command per (latency + 1) cycles.
- cmd_* inputs are sampled only at the handshake edge; later changes have no effect.

## Test plan
- **LOAD:** reset, then LOAD data=8'hA5 → sr_s=11 for exactly 1 cycle; done 2 cycles after handshake; result=8'hA5; aborted=0.
- **SHL:** LOAD 8'h81, then SHL cnt=3 fill=1 → three cycles of sr_s=01; result=8'h0F.
- **SHR and ROTL:** LOAD 8'h81, SHR cnt=2 fill=0 → result=8'h20. LOAD 8'h81, ROTL cnt=9 → result=8'h03 (wrap-around).
- **cnt=0 and ready:** SHL cnt=0 → done 1 cycle after handshake, sr_s never leaves 00, result=8'h81. cmd_valid held high in DONE → not accepted until IDLE.
- **abort:** LOAD 8'hFF, SHR cnt=8 fill=0, abort asserted during the 3rd SHIFT cycle → done next cycle, aborted=1, result=8'h1F.
- **Reset mid-SHIFT:** assert reset in the 2nd cycle of SHL cnt=5 → all outputs at reset values immediately; no done pulse; cmd_ready=1 after deassert; a following LOAD 8'h3C completes normally.
